// File: rtl/qa_sample_pacer_if.sv
// qa_sample_pacer_if
//   Sample stream bundle: one 32-bit sample qualified by a single-cycle strobe.
//   Used for both the bursty QA-block side (strobe = new-data) and the paced
//   RX-chain side (strobe = sample valid).
//   Signals:
//     sample  32  sample word
//     strobe   1  sample valid this cycle
//   Modports:
//     master  drives sample/strobe
//     slave   receives sample/strobe
interface qa_sample_pacer_if;
   logic [31:0] sample;
   logic        strobe;

   modport master (output sample, output strobe);
   modport slave  (input  sample, input  strobe);
endinterface

// File: rtl/qa_sample_pacer.sv
// qa_sample_pacer
//   Rate matcher between a bursty QA-block output and the RX chain, which wants
//   exactly one sample per strobe at a steady rate. Samples land in a
//   2^DEPTH_LOG FIFO and are released on a programmable periodic tick.
//   Overflow (drop on full) and underrun (tick on empty) counts saturate at
//   0xFFFF and are exposed on readback_o.
//   Settings: BASE+0 period[15:0] (tick every period+1 active cycles)
//             BASE+1 bit0 enable, bit1 clear (pulse, not stored), bit2 skip_on_empty
//   Ports:
//     clk_i, reset_i      clock, synchronous active-high reset
//     set_stb_i/addr/data settings bus
//     run_i               RX run flag; low flushes FIFO and stops ticks
//     in_if  (slave)      bursty sample input (strobe = new data)
//     out_if (master)     paced sample output (strobe = one-cycle valid)
//     occupancy_o         FIFO fill level
//     readback_o          {overflow_cnt, underrun_cnt}
module qa_sample_pacer #(
   parameter logic [7:0] BASE      = 8'd0,
   parameter int         DEPTH_LOG = 4
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 set_stb_i,
   input  logic [7:0]           set_addr_i,
   input  logic [31:0]          set_data_i,
   input  logic                 run_i,
   qa_sample_pacer_if.slave     in_if,
   qa_sample_pacer_if.master    out_if,
   output logic [DEPTH_LOG:0]   occupancy_o,
   output logic [31:0]          readback_o
);

   localparam int                   DEPTH   = 1 << DEPTH_LOG;
   localparam logic [DEPTH_LOG-1:0] PTR_ONE = 1;
   localparam logic [DEPTH_LOG:0]   CNT_ONE = 1;
   localparam logic [7:0]           A_PER   = BASE;
   localparam logic [7:0]           A_CTL   = BASE + 8'd1;

   logic [15:0]          period_q, period_d;
   logic                 enable_q, enable_d;
   logic                 skip_q, skip_d;
   logic [15:0]          cnt_q, cnt_d;
   logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG:0]   count_q, count_d;
   logic [15:0]          ovf_q, ovf_d, und_q, und_d;
   logic [31:0]          sample_q, sample_d;
   logic                 strobe_q, strobe_d;
   logic [31:0]          mem_q [DEPTH];

   logic wr_ctl, clear, active, tick, empty, full;
   logic pop, push, overflow, underrun, zero_fill;

   // Only period[15:0] and control bits [2:0] are meaningful.
   logic unused_bits;
   assign unused_bits = ^{set_data_i[31:16]};

   assign wr_ctl   = set_stb_i && (set_addr_i == A_CTL);
   // clear acts in the strobe cycle so it can override a coincident push/tick.
   assign clear    = wr_ctl & set_data_i[1];
   assign active   = enable_q & run_i;
   assign tick     = active & (cnt_q == 16'd0);
   assign empty    = (count_q == '0);
   assign full     = count_q[DEPTH_LOG];
   // No fall-through: the pop decision uses the registered fill, so a sample
   // pushed in a tick cycle on an empty FIFO waits for the next tick.
   assign pop      = tick & ~empty & ~clear;
   assign underrun = tick &  empty & ~clear;
   assign zero_fill = underrun & ~skip_q;
   assign push     = run_i & in_if.strobe & ~clear & (~full | pop);
   assign overflow = run_i & in_if.strobe & ~clear & full & ~pop;

   always_comb begin
      period_d = period_q;
      enable_d = enable_q;
      skip_d   = skip_q;
      if (set_stb_i && (set_addr_i == A_PER)) period_d = set_data_i[15:0];
      if (wr_ctl) begin
         enable_d = set_data_i[0];
         skip_d   = set_data_i[2];
      end

      // Reload whenever idle or on tick, so period changes apply at reload
      // and a run drop restarts a full interval.
      cnt_d = (!active || cnt_q == 16'd0) ? period_q : cnt_q - 16'd1;

      wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      if (!run_i || clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end

      ovf_d = ovf_q;
      und_d = und_q;
      if (overflow && ovf_q != 16'hFFFF) ovf_d = ovf_q + 16'd1;
      if (underrun && und_q != 16'hFFFF) und_d = und_q + 16'd1;
      if (clear) begin
         ovf_d = '0;
         und_d = '0;
      end

      strobe_d = pop | zero_fill;
      sample_d = sample_q;
      if (pop)            sample_d = mem_q[rd_ptr_q];
      else if (zero_fill) sample_d = '0;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         period_q <= '0;
         enable_q <= 1'b0;
         skip_q   <= 1'b0;
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= '0;
         und_q    <= '0;
         sample_q <= '0;
         strobe_q <= 1'b0;
      end else begin
         period_q <= period_d;
         enable_q <= enable_d;
         skip_q   <= skip_d;
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         und_q    <= und_d;
         sample_q <= sample_d;
         strobe_q <= strobe_d;
      end
   end

   // Storage needs no reset; entries are only read when count_q says valid.
   always_ff @(posedge clk_i) begin
      if (push && !reset_i) mem_q[wr_ptr_q] <= in_if.sample;
   end

   assign out_if.sample = sample_q;
   assign out_if.strobe = strobe_q;
   assign occupancy_o   = count_q;
   assign readback_o    = {ovf_q, und_q};

endmodule

// File: tb/tb_qa_sample_pacer.sv
// tb_qa_sample_pacer
//   Bench for qa_sample_pacer: a queue-based reference model (tick = every
//   period+1 active cycles, FIFO as a queue) checked against the DUT on every
//   cycle, plus directed scenarios with hand-computed expectations.
module tb_qa_sample_pacer;
   localparam logic [7:0] BASE  = 8'h40;
   localparam logic [7:0] A_PER = BASE;
   localparam logic [7:0] A_CTL = BASE + 8'd1;
   localparam logic [7:0] A_OTH = BASE + 8'd2;
   localparam int DEPTH_LOG = 4;
   localparam int DEPTH = 1 << DEPTH_LOG;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        set_stb = 1'b0;
   logic [7:0]  set_addr = '0;
   logic [31:0] set_data = '0;
   logic        run = 1'b1;
   logic [DEPTH_LOG:0] occupancy;
   logic [31:0] readback;

   qa_sample_pacer_if in_bus ();
   qa_sample_pacer_if out_bus ();

   qa_sample_pacer #(.BASE(BASE), .DEPTH_LOG(DEPTH_LOG)) dut (
      .clk_i(clk), .reset_i(reset), .set_stb_i(set_stb), .set_addr_i(set_addr),
      .set_data_i(set_data), .run_i(run), .in_if(in_bus), .out_if(out_bus),
      .occupancy_o(occupancy), .readback_o(readback));

   always #5 clk = ~clk;

   int tests = 0, fails = 0, cyc = 0, c0 = 0;
   bit rec_en = 1'b0;
   int rec_t[$];
   logic [31:0] rec_d[$];

   // reference model state
   logic [31:0] mq[$];
   int m_ovf = 0, m_und = 0, m_period = 0, m_runlen = 0, m_curper = 0;
   bit m_en = 1'b0, m_skip = 1'b0, m_strobe = 1'b0;
   logic [31:0] m_sample = '0;
   bit m_clr, m_act, m_tk, m_pop, m_full;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         if (fails <= 40) $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      if (reset) begin
         mq.delete();
         m_ovf = 0; m_und = 0; m_period = 0; m_runlen = 0; m_curper = 0;
         m_en = 0; m_skip = 0; m_strobe = 0; m_sample = '0;
      end else begin
         m_clr = set_stb && set_addr == A_CTL && set_data[1];
         m_act = m_en && run;
         m_tk  = 1'b0;
         if (!m_act) begin
            m_curper = m_period; m_runlen = 0;
         end else if (m_runlen == m_curper) begin
            m_tk = 1'b1; m_runlen = 0; m_curper = m_period;
         end else m_runlen++;
         m_full = (mq.size() == DEPTH);
         m_pop = 1'b0;
         m_strobe = 1'b0;
         if (m_tk && !m_clr) begin
            if (mq.size() > 0) begin
               m_sample = mq.pop_front(); m_strobe = 1'b1; m_pop = 1'b1;
            end else begin
               if (m_und < 65535) m_und++;
               if (!m_skip) begin m_strobe = 1'b1; m_sample = '0; end
            end
         end
         if (run && in_bus.strobe && !m_clr) begin
            if (!m_full || m_pop) mq.push_back(in_bus.sample);
            else if (m_ovf < 65535) m_ovf++;
         end
         if (!run || m_clr) mq.delete();
         if (m_clr) begin m_ovf = 0; m_und = 0; end
         if (set_stb && set_addr == A_PER) m_period = int'(set_data[15:0]);
         if (set_stb && set_addr == A_CTL) begin m_en = set_data[0]; m_skip = set_data[2]; end
      end
   end

   always @(negedge clk) begin
      chk("strobe", {31'd0, out_bus.strobe}, {31'd0, m_strobe});
      chk("sample", out_bus.sample, m_sample);
      chk("occupancy", {27'd0, occupancy}, mq.size());
      chk("readback", readback, {m_ovf[15:0], m_und[15:0]});
      if (rec_en && out_bus.strobe) begin
         rec_t.push_back(cyc - c0);
         rec_d.push_back(out_bus.sample);
      end
   end

   task automatic step();
      @(posedge clk); #2;
      set_stb = 1'b0;
      in_bus.strobe = 1'b0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      set_stb = 1'b1; set_addr = a; set_data = d;
      step();
   endtask

   task automatic push(input logic [31:0] d);
      in_bus.strobe = 1'b1; in_bus.sample = d;
   endtask

   task automatic rec_start();
      rec_t.delete(); rec_d.delete(); rec_en = 1'b1; c0 = cyc;
   endtask

   initial begin
      int nd_pct;
      in_bus.strobe = 1'b0; in_bus.sample = '0;
      repeat (2) step();
      reset = 1'b0;
      step();
      chk("rst_occ", {27'd0, occupancy}, 0);
      chk("rst_rb", readback, 0);
      chk("rst_strobe", {31'd0, out_bus.strobe}, 0);

      // steady rate: enable lands with first push (cycle 0), ticks at 4,8,12,16
      wr(A_PER, 3);
      rec_start();
      set_stb = 1'b1; set_addr = A_CTL; set_data = 1;
      for (int i = 1; i <= 4; i++) begin push(i); step(); end
      repeat (16) step();
      rec_en = 1'b0;
      chk("steady_n", rec_t.size(), 4);
      for (int i = 0; i < rec_t.size() && i < 4; i++) begin
         chk("steady_t", rec_t[i], 5 + 4 * i);
         chk("steady_d", rec_d[i], i + 1);
      end
      chk("steady_rb", readback, 0);
      wr(A_CTL, 0);

      // overflow: 20 pushes into 16 deep, no ticks
      wr(A_PER, 16'hFFFF);
      wr(A_CTL, 3);
      for (int i = 0; i < 20; i++) begin push(32'h100 + i); step(); end
      step();
      chk("ovf_occ", {27'd0, occupancy}, 16);
      chk("ovf_rb", readback, 32'h0004_0000);
      wr(A_PER, 0);
      wr(A_CTL, 0);
      rec_start();
      wr(A_CTL, 5);
      repeat (20) step();
      rec_en = 1'b0;
      chk("ovf_drain_n", rec_t.size(), 16);
      for (int i = 0; i < rec_t.size() && i < 16; i++) begin
         chk("ovf_drain_d", rec_d[i], 32'h100 + i);
         chk("ovf_drain_t", rec_t[i], rec_t[0] + i);
      end
      wr(A_CTL, 0);

      // underrun zero-fill, then skip
      wr(A_CTL, 2);
      wr(A_PER, 1);
      rec_start();
      wr(A_CTL, 1);
      repeat (9) step();
      wr(A_CTL, 0);
      repeat (2) step();
      rec_en = 1'b0;
      chk("und_n", rec_t.size(), 5);
      for (int i = 0; i < rec_t.size(); i++) chk("und_zero", rec_d[i], 0);
      chk("und_rb", readback, 5);
      rec_start();
      wr(A_CTL, 5);
      repeat (9) step();
      wr(A_CTL, 4);
      repeat (2) step();
      rec_en = 1'b0;
      chk("skip_n", rec_t.size(), 0);
      chk("skip_rb", readback, 10);

      // push in a tick cycle on empty FIFO
      wr(A_CTL, 2);
      wr(A_PER, 3);
      rec_start();
      wr(A_CTL, 1);
      repeat (3) step();
      push(32'hDEADBEEF); step();
      repeat (4) step();
      wr(A_CTL, 0);
      step();
      rec_en = 1'b0;
      chk("pot_n", rec_t.size(), 2);
      if (rec_t.size() >= 2) begin
         chk("pot_t0", rec_t[0], 5); chk("pot_d0", rec_d[0], 0);
         chk("pot_t1", rec_t[1], 9); chk("pot_d1", rec_d[1], 32'hDEADBEEF);
      end
      chk("pot_rb", readback, 1);

      // run drop flushes a full FIFO, in_nd ignored, then clear
      for (int i = 0; i < DEPTH; i++) begin push(32'h200 + i); step(); end
      chk("run_full", {27'd0, occupancy}, 16);
      run = 1'b0; push(32'h55); step();
      chk("run_occ", {27'd0, occupancy}, 0);
      chk("run_rb", readback, 1);
      run = 1'b1;
      wr(A_CTL, 2);
      chk("clear_rb", readback, 0);

      // randomized traffic against the model
      nd_pct = 50;
      for (int n = 0; n < 3000; n++) begin
         if (n % 200 == 0) nd_pct = (n / 200) % 3 == 0 ? 30 : ((n / 200) % 3 == 1 ? 60 : 95);
         if ($urandom_range(19) == 0) begin
            set_stb = 1'b1;
            case ($urandom_range(2))
               0: begin set_addr = A_PER; set_data = $urandom_range(4); end
               1: begin
                  set_addr = A_CTL;
                  set_data = {29'd0, 1'($urandom_range(1)), 1'($urandom_range(11) == 0),
                              1'($urandom_range(7) != 0)};
               end
               default: begin set_addr = A_OTH; set_data = $urandom; end
            endcase
         end
         run = ($urandom_range(24) != 0);
         if ($urandom_range(99) < nd_pct) push($urandom);
         step();
      end
      run = 1'b1;

      // reset mid-stream while ticking with a non-empty FIFO
      wr(A_CTL, 2);
      wr(A_PER, 1);
      wr(A_CTL, 1);
      for (int i = 0; i < 8; i++) begin push(32'h300 + i); step(); end
      reset = 1'b1; step(); reset = 1'b0;
      chk("mrst_strobe", {31'd0, out_bus.strobe}, 0);
      chk("mrst_sample", out_bus.sample, 0);
      chk("mrst_occ", {27'd0, occupancy}, 0);
      chk("mrst_rb", readback, 0);
      rec_start();
      for (int i = 0; i < 10; i++) begin push(32'h400 + i); step(); end
      step();
      rec_en = 1'b0;
      chk("mrst_nostrobe", rec_t.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
